// File: rtl/cic_dec_ctrl.sv
// cic_dec_ctrl: sequences an external CIC decimator (clear, settle, run),
// feeds it input samples and buffers its scaled outputs in a small FWFT FIFO.
// Optional build macro CIC_DEC_CTRL_ROUND_EN selects round-half-up scaling
// with positive saturation instead of plain truncation.
module cic_dec_ctrl #(
    parameter int unsigned INPUT_WIDTH     = 15,
    parameter int unsigned CIC_WIDTH       = 38,
    parameter int unsigned OUT_WIDTH       = 16,
    parameter int unsigned DECIMATION_RATE = 12,
    parameter int unsigned SETTLE_DISCARD  = 5,
    parameter int unsigned CLEAR_CYCLES    = 2,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          flush,
    input  logic                          s_valid,
    input  logic signed [INPUT_WIDTH-1:0] s_data,
    output logic                          s_ready,
    output logic                          cic_rst,
    output logic                          cic_nd,
    output logic [INPUT_WIDTH-1:0]        cic_din,
    input  logic                          cic_rdy,
    input  logic signed [CIC_WIDTH-1:0]   cic_dout,
    output logic                          m_valid,
    output logic signed [OUT_WIDTH-1:0]   m_data,
    input  logic                          m_ready,
    output logic                          busy,
    output logic                          overflow
);

    localparam int unsigned CLR_W = $clog2(CLEAR_CYCLES + 1);
    localparam int unsigned SET_W = $clog2(SETTLE_DISCARD + 1);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned DROP_W = CIC_WIDTH - OUT_WIDTH;

    typedef enum logic [1:0] {IDLE, CLEAR, SETTLE, RUN} state_t;

    state_t               state_q, state_d;
    logic [CLR_W-1:0]     clr_q, clr_d;
    logic [SET_W-1:0]     set_q, set_d;
    logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_q, rd_q;
    logic [CNT_W-1:0]     count_q;
    logic [OUT_WIDTH-1:0] scaled;
    logic                 full, push, pop, push_ok, accept;

    // Output scaling of the decimator word
`ifdef CIC_DEC_CTRL_ROUND_EN
    localparam logic [CIC_WIDTH:0] HALF = (CIC_WIDTH + 1)'(1) << (DROP_W - 1);
    logic [CIC_WIDTH:0] rnd_sum;
    logic               unused_rnd_lsbs;
    assign rnd_sum         = {cic_dout[CIC_WIDTH-1], cic_dout} + HALF;
    assign unused_rnd_lsbs = ^rnd_sum[DROP_W-1:0];
    // adding a positive half-LSB can only overflow upward
    assign scaled = (rnd_sum[CIC_WIDTH] != rnd_sum[CIC_WIDTH-1])
                  ? {1'b0, {(OUT_WIDTH-1){1'b1}}}
                  : rnd_sum[CIC_WIDTH-1 -: OUT_WIDTH];
`else
    logic unused_trunc_lsbs;
    assign unused_trunc_lsbs = ^cic_dout[DROP_W-1:0];
    assign scaled = cic_dout[CIC_WIDTH-1 -: OUT_WIDTH];
`endif

    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign m_valid = (count_q != '0);
    assign m_data  = m_valid ? mem[rd_q] : '0;
    assign cic_rst = (state_q == CLEAR);
    assign busy    = (state_q != IDLE) || m_valid;
    assign s_ready = en && ((state_q == SETTLE) || (state_q == RUN)) && !full && !flush;
    assign accept  = s_valid && s_ready;
    assign push    = (state_q == RUN) && cic_rdy && !flush;
    assign pop     = m_valid && m_ready && !flush;
    assign push_ok = push && (!full || pop);

    // Next-state and sequencing counters
    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        set_d   = set_q;
        if (flush) begin
            state_d = CLEAR;
            clr_d   = '0;
            set_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en) begin
                        state_d = CLEAR;
                        clr_d   = '0;
                    end
                end
                CLEAR: begin
                    if (clr_q == CLR_W'(CLEAR_CYCLES - 1)) begin
                        state_d = SETTLE;
                        clr_d   = '0;
                        set_d   = '0;
                    end else begin
                        clr_d = clr_q + CLR_W'(1);
                    end
                end
                SETTLE: begin
                    if (!en) begin
                        state_d = IDLE;
                    end else if (cic_rdy) begin
                        if (set_q == SET_W'(SETTLE_DISCARD - 1)) begin
                            state_d = RUN;
                            set_d   = '0;
                        end else begin
                            set_d = set_q + SET_W'(1);
                        end
                    end
                end
                RUN: begin
                    if (!en) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            clr_q   <= '0;
            set_q   <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            set_q   <= set_d;
        end
    end

    // Input sample forwarding to the decimator, one cycle latency
    always_ff @(posedge clk) begin
        if (rst) begin
            cic_nd  <= 1'b0;
            cic_din <= '0;
        end else begin
            cic_nd <= accept;
            if (accept) cic_din <= s_data;
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_q] <= scaled;
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_q     <= '0;
            rd_q     <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push && !push_ok) overflow <= 1'b1;
            if (push_ok) wr_q <= (wr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_q + PTR_W'(1);
            if (pop)     rd_q <= (rd_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_q + PTR_W'(1);
            if (push_ok && !pop)      count_q <= count_q + CNT_W'(1);
            else if (!push_ok && pop) count_q <= count_q - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cic_dec_ctrl.sv
// Scoreboard bench for cic_dec_ctrl with a behavioural model of the sequencer
// and output buffer. Honours CIC_DEC_CTRL_ROUND_EN for the expected scaling.
module tb_cic_dec_ctrl;

    localparam int IW = 15;
    localparam int CW = 38;
    localparam int OW = 16;
    localparam int DEPTH = 4;
    localparam int NCLR = 2;
    localparam int NSET = 5;

    logic                 clk, rst, en, flush, s_valid, s_ready;
    logic signed [IW-1:0] s_data;
    logic                 cic_rst, cic_nd, cic_rdy;
    logic [IW-1:0]        cic_din;
    logic signed [CW-1:0] cic_dout;
    logic                 m_valid, m_ready, busy, overflow;
    logic signed [OW-1:0] m_data;

    cic_dec_ctrl dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .cic_rst(cic_rst), .cic_nd(cic_nd), .cic_din(cic_din),
        .cic_rdy(cic_rdy), .cic_dout(cic_dout),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .busy(busy), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {M_IDLE, M_CLEAR, M_SETTLE, M_RUN} mphase_t;

    int      total = 0;
    int      bad = 0;
    mphase_t ph = M_IDLE;
    int      clr_n = 0, set_n = 0, occ = 0;
    bit      m_ovf = 0, m_nd = 0;
    longint  m_din = 0;
    longint  exp_q[$];
    logic [CW-1:0] dtab [5];

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected output word from the arithmetic definition of the scaling
    function automatic longint scale(input logic signed [CW-1:0] d);
        longint x, r;
        x = d;
`ifdef CIC_DEC_CTRL_ROUND_EN
        r = (x + (longint'(1) << (CW - OW - 1))) >>> (CW - OW);
        if (r > 32767) r = 32767;
`else
        r = x >>> (CW - OW);
`endif
        return r;
    endfunction

    function automatic logic signed [CW-1:0] rnd_dout();
        logic [63:0] w;
        if ($urandom_range(0, 3) == 0) return dtab[$urandom_range(0, 4)];
        w = {$urandom, $urandom};
        return CW'(w);
    endfunction

    // Monitor: every accepted output word must match the oldest expected one
    always @(negedge clk) begin
        if (!rst && m_valid === 1'b1 && m_ready === 1'b1) begin
            if (exp_q.size() == 0) check("pop_unexpected", 1, 0);
            else check("m_data", longint'(m_data), exp_q.pop_front());
        end
    end

    // One clock of stimulus, pre-edge output checks, then model update
    task automatic cycle(input bit i_rst, input bit i_en, input bit i_fl, input bit i_sv,
                         input bit i_rdy, input bit i_mr, input logic signed [CW-1:0] i_d);
        bit exp_sr, pop, push;
        longint sd;
        @(posedge clk); #1;
        rst = i_rst; en = i_en; flush = i_fl; s_valid = i_sv;
        cic_rdy = i_rdy; m_ready = i_mr; cic_dout = i_d;
        s_data = IW'($urandom);
        sd = s_data;
        exp_sr = i_en && (ph == M_SETTLE || ph == M_RUN) && occ < DEPTH && !i_fl;
        @(negedge clk);
        check("s_ready", s_ready, exp_sr);
        check("cic_rst", cic_rst, ph == M_CLEAR);
        check("busy", busy, ph != M_IDLE || occ > 0);
        check("overflow", overflow, m_ovf);
        check("m_valid", m_valid, occ > 0);
        check("cic_nd", cic_nd, m_nd);
        check("cic_din", cic_din, m_din);
        if (occ == 0) check("m_data_empty", longint'(m_data), 0);
        #1;
        if (i_rst) begin
            ph = M_IDLE; clr_n = 0; set_n = 0; occ = 0; m_ovf = 0;
            m_nd = 0; m_din = 0; exp_q.delete();
        end else begin
            m_nd = i_sv && exp_sr;
            if (m_nd) m_din = sd & ((longint'(1) << IW) - 1);
            if (i_fl) begin
                ph = M_CLEAR; clr_n = 0; set_n = 0; occ = 0; m_ovf = 0;
                exp_q.delete();
            end else begin
                pop  = occ > 0 && i_mr;
                push = ph == M_RUN && i_rdy;
                if (push) begin
                    if (occ == DEPTH && !pop) m_ovf = 1;
                    else begin
                        exp_q.push_back(scale(i_d));
                        occ++;
                    end
                end
                if (pop) occ--;
                case (ph)
                    M_IDLE:  if (i_en) begin ph = M_CLEAR; clr_n = 0; end
                    M_CLEAR: begin
                        clr_n++;
                        if (clr_n == NCLR) begin ph = M_SETTLE; set_n = 0; end
                    end
                    M_SETTLE: begin
                        if (!i_en) ph = M_IDLE;
                        else if (i_rdy) begin
                            set_n++;
                            if (set_n == NSET) ph = M_RUN;
                        end
                    end
                    M_RUN: if (!i_en) ph = M_IDLE;
                    default: ph = M_IDLE;
                endcase
            end
        end
    endtask

    initial begin
        longint lit;
        dtab[0] = 38'h0123456789; dtab[1] = 38'h0000600000; dtab[2] = 38'h1FFFFFFFFF;
        dtab[3] = 38'h2000000000; dtab[4] = 38'h3FFFFFFFFF;
        rst = 1; en = 0; flush = 0; s_valid = 0; s_data = '0;
        cic_rdy = 0; cic_dout = '0; m_ready = 0;

        repeat (3) cycle(1, 0, 0, 0, 0, 0, '0);
        // start-up: clear, settle discards, then three known words plus one
        repeat (3) cycle(0, 1, 0, 1, 0, 0, '0);
        repeat (NSET) cycle(0, 1, 0, 1, 1, 0, rnd_dout());
        cycle(0, 1, 0, 1, 1, 0, 38'h0123456789);
        cycle(0, 1, 0, 1, 1, 0, 38'h0000600000);
        cycle(0, 1, 0, 1, 1, 0, 38'h1FFFFFFFFF);
        cycle(0, 1, 0, 1, 1, 0, rnd_dout());
        cycle(0, 1, 0, 1, 1, 0, rnd_dout());       // dropped: buffer full
        cycle(0, 1, 0, 1, 0, 0, '0);
        check("ovf_sticky", overflow, 1);
        check("word0", longint'(m_data), 'h048D);
        cycle(0, 1, 0, 1, 0, 1, '0);
        cycle(0, 1, 0, 1, 0, 0, '0);
`ifdef CIC_DEC_CTRL_ROUND_EN
        lit = 'h0002;
`else
        lit = 'h0001;
`endif
        check("word1", longint'(m_data), lit);
        cycle(0, 1, 0, 1, 0, 1, '0);
        cycle(0, 1, 0, 1, 0, 0, '0);
        check("word2", longint'(m_data), 'h7FFF);
        // flush with two words buffered and overflow set
        cycle(0, 1, 1, 1, 0, 0, '0);
        cycle(0, 1, 0, 1, 1, 0, rnd_dout());
        check("flush_empty", m_valid, 0);
        check("flush_ovf", overflow, 0);
        cycle(0, 1, 0, 1, 1, 0, rnd_dout());
        repeat (NSET) cycle(0, 1, 0, 1, 1, 0, rnd_dout());
        repeat (DEPTH) cycle(0, 1, 0, 1, 1, 0, rnd_dout());
        // full buffer with simultaneous pop and push
        cycle(0, 1, 0, 1, 1, 1, rnd_dout());
        cycle(0, 1, 0, 1, 0, 0, '0);
        check("full_pop_push_ovf", overflow, 0);
        repeat (DEPTH) cycle(0, 1, 0, 1, 0, 1, '0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 299) == 0, $urandom_range(0, 19) != 0,
                  $urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 6, rnd_dout());
        end

        // reset in RUN with three words buffered
        cycle(0, 1, 1, 0, 0, 0, '0);
        repeat (NCLR) cycle(0, 1, 0, 0, 0, 0, '0);
        repeat (NSET) cycle(0, 1, 0, 0, 1, 0, rnd_dout());
        repeat (3) cycle(0, 1, 0, 1, 1, 0, rnd_dout());
        cycle(1, 1, 0, 1, 1, 1, rnd_dout());
        cycle(0, 0, 0, 0, 0, 0, '0);
        check("rst_busy", busy, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_cic_din", cic_din, 0);
        repeat (3) cycle(0, 0, 0, 0, 0, 0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
